shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 5, width of the pass-count input (max passes 2^CNT_W-1).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new sequence; accepted only when ready=1.
REQ-005 SHALL have port op  input  1  0 = arithmetic right shift by 1 per pass (shifter code 01); 1 = logical left shift by 8 per pass (shifter code 10).
REQ-006 SHALL have port count  input  CNT_W  number of shifter passes; sampled with start.
REQ-007 SHALL have port dataIn  input  32  operand; sampled with start.
REQ-008 SHALL have port shControl  output  2  control code driven to the external shifter.
REQ-009 SHALL have port shData  output  32  data driven to the external shifter.
REQ-010 SHALL have port shResult  input  32  combinational output of the external shifter.
REQ-011 SHALL have port ready  output  1  high in IDLE only.
REQ-012 SHALL have port busy  output  1  high in RUN only.
REQ-013 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-014 SHALL have port result  output  32  final value; held from DONE until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE with a 32-bit accumulator acc, a CNT_W-bit counter rem and a latched op bit.
REQ-016 IDLE: start=1 SHALL load acc<=dataIn, rem<=count, op latched; next state RUN if count!=0, else DONE.
REQ-017 start SHALL be ignored in RUN and DONE (no relatch, no state change).
REQ-018 RUN: shData SHALL equal acc and shControl SHALL be 01 (op=0) or 10 (op=1) combinationally from state.
REQ-019 RUN: each cycle acc<=shResult and rem<=rem-1; when rem==1, next state SHALL be DONE.
REQ-020 IDLE and DONE: shControl SHALL be 00 (bypass) and shData SHALL equal acc.
REQ-021 DONE: done=1 for exactly one cycle, result<=acc registered on DONE entry; next state IDLE unconditionally.
REQ-022 Latency: done SHALL assert count+1 cycles after the accepting edge (1 cycle for count=0); no early termination, even when acc reaches zero.
REQ-023 rem SHALL never wrap; decrement occurs only in RUN with rem>=1.
REQ-024 Back-to-back: start asserted in the IDLE cycle immediately following DONE SHALL be accepted.

Reset
REQ-025 reset=1 SHALL force, asynchronously and regardless of state, state=IDLE, acc=0, rem=0, op=0, result=0.
REQ-026 During and after reset: ready=1, busy=0, done=0, shControl=00, shData=0.
REQ-027 Reset mid-RUN SHALL discard the sequence; no done pulse SHALL be produced for it.

Configuration
REQ-028 Macro SHIFT_SEQ_ABORT_EN defined: SHALL add input port abort (1 bit); abort=1 in RUN SHALL move to IDLE next edge, leave result unchanged, emit no done; abort ignored in IDLE/DONE.
REQ-029 Macro SHIFT_SEQ_ABORT_EN undefined: port abort SHALL not exist; RUN always completes.

Verification
REQ-030 op=0, dataIn=0x80000000, count=3, start one cycle -> busy 3 cycles, done on 4th edge after start, result=0xF0000000, shControl=01 during RUN.
REQ-031 op=1, dataIn=0x000000AB, count=2 -> done 3 cycles after start, result=0x00AB0000; op=1, count=5 -> result=0x00000000 after 6 cycles.
REQ-032 count=0, dataIn=0x12345678 -> DONE next cycle, result=0x12345678, shControl stays 00.
REQ-033 start held high through RUN with different dataIn -> ignored; result matches first operand; second start accepted in the IDLE cycle after DONE.
REQ-034 reset asserted mid-RUN (count=10, after 4 passes) -> immediate IDLE, acc=result=0, no done pulse.
REQ-035 With SHIFT_SEQ_ABORT_EN: abort during RUN after prior result 0x0000FFFF -> IDLE next edge, result remains 0x0000FFFF, done stays 0.

Source files
------------

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Drives an external combinational shifter for a programmable number of
// passes.  A sequence is requested with start while ready=1.  The operand,
// pass count and shift kind are captured at that edge.  The block then feeds
// the running accumulator to the shifter once per cycle and captures the
// shifter output back each cycle.  When the last pass lands, the final value
// is published on result and done pulses for one cycle.
//
// Shift kinds (shControl code driven to the shifter while running):
//   op=0 -> 2'b01 : arithmetic right shift by 1 per pass
//   op=1 -> 2'b10 : logical left shift by 8 per pass
//   idle / done   -> 2'b00 : bypass
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an abort input.  When
// abort is high during RUN, the running sequence is dropped and the block
// returns to IDLE on the next edge without touching result and without a
// done pulse.  Without the macro the port does not exist and every sequence
// runs to completion.
//
// Ports
//   clock     in   1      sole clock, rising edge
//   reset     in   1      asynchronous active-high reset
//   start     in   1      sequence request, honoured only when ready=1
//   op        in   1      shift kind, sampled with start
//   count     in   CNT_W  number of shifter passes, sampled with start
//   dataIn    in   32     operand, sampled with start
//   abort     in   1      (SHIFT_SEQ_ABORT_EN only) drop the running sequence
//   shControl out  2      control code to the external shifter
//   shData    out  32     data to the external shifter (always the accumulator)
//   shResult  in   32     combinational output of the external shifter
//   ready     out  1      high in IDLE
//   busy      out  1      high in RUN
//   done      out  1      one-cycle pulse in DONE
//   result    out  32     final value, held until the next accepted start
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      dataIn,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       shControl,
  output logic [31:0]      shData,
  input  logic [31:0]      shResult,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             op_q, op_d;
  logic [31:0]      result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_s;

  // Abort request, tied off when the feature is not built in.
`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and datapath computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = dataIn;
          rem_d = count;
          op_d  = op;
          if (count != REM_ZERO) begin
            state_d = S_RUN;
          end else begin
            // Zero passes: the operand itself is the answer.
            state_d  = S_DONE;
            result_d = dataIn;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else begin
          acc_d = shResult;
          // Guarded decrement so rem can never wrap below zero.
          if (rem_q != REM_ZERO) begin
            rem_d = rem_q - REM_ONE;
          end else begin
            rem_d = rem_q;
          end
          // Last pass: publish the shifter output as the result on DONE entry.
          // rem==0 cannot occur here, but is treated as last to avoid lock-up.
          if (rem_q <= REM_ONE) begin
            state_d  = S_DONE;
            result_d = shResult;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered, decoded from the upcoming state.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State, datapath and status registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'd0;
      rem_q    <= REM_ZERO;
      op_q     <= 1'b0;
      result_q <= 32'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Shifter control follows the current state; bypass outside RUN.
  always_comb begin
    case (state_q)
      S_RUN:   shControl = op_q ? 2'b10 : 2'b01;
      S_IDLE:  shControl = 2'b00;
      S_DONE:  shControl = 2'b00;
      default: shControl = 2'b00;
    endcase
  end

  assign shData = acc_q;
  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer.  Models the external shifter as a
// combinational block, drives directed and random sequences, and compares
// every observable against closed-form expectations (final value computed
// directly from op, operand and pass count; latency count+1).
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [4:0]  count;
  logic [31:0] dataIn;
  logic [1:0]  shControl;
  logic [31:0] shData;
  logic [31:0] shResult;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
  logic        abort;
`endif

  int n_checks;
  int n_pass;

  shift_sequencer #(.CNT_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .count    (count),
    .dataIn   (dataIn),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .shControl(shControl),
    .shData   (shData),
    .shResult (shResult),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // External shifter.
  always_comb begin
    case (shControl)
      2'b01:   shResult = {shData[31], shData[31:1]};
      2'b10:   shResult = shData << 8;
      default: shResult = shData;
    endcase
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value after n passes, computed directly rather than pass by pass.
  function automatic logic [31:0] ref_val(input logic o, input logic [31:0] d, input int n);
    if (o) begin
      ref_val = (n >= 4) ? 32'd0 : (d << (8 * n));
    end else begin
      ref_val = 32'($signed(d) >>> n);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one sequence from the IDLE state and check it cycle by cycle.
  // Returns at the negedge where done is high.  With hold=1, start stays
  // high during RUN with different operand/op/count (must be ignored).
  task automatic run_seq(input logic o, input logic [4:0] n, input logic [31:0] d,
                         input logic hold);
    int cyc;
    logic [1:0] code;
    code = o ? 2'b10 : 2'b01;
    @(negedge clock);
    chk("ready_before", {31'd0, ready}, 32'd1);
    start = 1'b1; op = o; count = n; dataIn = d;
    @(negedge clock);
    if (hold) begin
      dataIn = ~d; op = ~o; count = 5'd1;
    end else begin
      start = 1'b0;
    end
    cyc = 1;
    while (done !== 1'b1 && cyc <= 40) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("ready_run", {31'd0, ready}, 32'd0);
      chk("shctl_run", {30'd0, shControl}, {30'd0, code});
      chk("shdata_run", shData, ref_val(o, d, cyc - 1));
      @(negedge clock);
      cyc++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("latency", cyc, 32'(n) + 32'd1);
    chk("result", result, ref_val(o, d, int'(n)));
    chk("shctl_done", {30'd0, shControl}, 32'd0);
    chk("shdata_done", shData, ref_val(o, d, int'(n)));
    chk("busy_done", {31'd0, busy}, 32'd0);
    if (!hold) begin
      @(negedge clock);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("ready_idle", {31'd0, ready}, 32'd1);
      chk("result_hold", result, ref_val(o, d, int'(n)));
      chk("shctl_idle", {30'd0, shControl}, 32'd0);
    end
  endtask

  initial begin
    logic        ro;
    logic [4:0]  rn;
    logic [31:0] rd;
    logic        seen_done;
    n_checks = 0;
    n_pass   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    count  = 5'd0;
    dataIn = 32'd0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort  = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_shctl", {30'd0, shControl}, 32'd0);
    chk("rst_shdata", shData, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    // Directed cases.
    run_seq(1'b0, 5'd3, 32'h8000_0000, 1'b0);
    chk("asr3_value", result, 32'hF000_0000);
    run_seq(1'b1, 5'd2, 32'h0000_00AB, 1'b0);
    chk("shl2_value", result, 32'h00AB_0000);
    run_seq(1'b1, 5'd5, 32'h0000_00AB, 1'b0);
    chk("shl5_value", result, 32'h0000_0000);
    run_seq(1'b0, 5'd0, 32'h1234_5678, 1'b0);
    chk("cnt0_value", result, 32'h1234_5678);
    run_seq(1'b0, 5'd31, 32'h8000_0001, 1'b0);
    chk("asr31_value", result, 32'hFFFF_FFFF);
    run_seq(1'b0, 5'd2, 32'h0000_0004, 1'b0);

    // Start held high through RUN, then back-to-back accept after DONE.
    run_seq(1'b0, 5'd4, 32'h8000_1234, 1'b1);
    @(negedge clock);
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    chk("b2b_result_first", result, ref_val(1'b0, 32'h8000_1234, 4));
    @(negedge clock);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    @(negedge clock);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_result_second", result, ref_val(1'b1, ~32'h8000_1234, 1));
    @(negedge clock);

    // Random sequences.
    for (int i = 0; i < 25; i++) begin
      ro = 1'($urandom_range(0, 1));
      rn = 5'($urandom_range(0, 9));
      rd = $urandom;
      run_seq(ro, rn, rd, 1'b0);
    end

    // Reset in the middle of RUN after 4 passes.
    run_seq(1'b1, 5'd1, 32'h00C0_FFEE, 1'b0);
    @(negedge clock);
    start = 1'b1; op = 1'b0; count = 5'd10; dataIn = 32'h8000_0000;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_rst_shdata", shData, ref_val(1'b0, 32'h8000_0000, 4));
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_shctl", {30'd0, shControl}, 32'd0);
    chk("midrst_shdata", shData, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
    chk("midrst_idle", {31'd0, ready}, 32'd1);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort during RUN keeps the previous result.
    run_seq(1'b0, 5'd0, 32'h0000_FFFF, 1'b0);
    @(negedge clock);
    start = 1'b1; op = 1'b1; count = 5'd5; dataIn = 32'h0000_0011;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_result", result, 32'h0000_FFFF);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    chk("abort_result_hold", result, 32'h0000_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
